// File: rtl/hevc_interp_8tap_if.sv
// write_interface: FIFO-style write handshake; din[W] is the tag bit, din[W-1:0] the payload.
`timescale 1ns/1ps
interface write_interface #(parameter int W = 8, parameter int FLUX = 2);
    logic [W:0] din;
    logic       write;
    logic       full;
    logic       unused_flux;
    assign unused_flux = ^FLUX;
    modport master (output din, write, input full);
    modport slave (input din, write, output full);
endinterface

// File: rtl/hevc_interp_8tap.sv
// hevc_interp_8tap: streaming HEVC luma 8-tap separable interpolation, horizontal then vertical pass.
// Define OUT_CLIP_EN to saturate results to 0..255; otherwise the low 8 bits are kept.
`timescale 1ns/1ps
module hevc_interp_fifo #(parameter int W = 8, parameter int DEPTH = 4, parameter int FLUX = 2) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         wr,
    output logic         full,
    output logic [W-1:0] dout,
    output logic         empty,
    input  logic         rd
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_wr, do_rd;
    // writes keep landing above the full threshold so a late producer loses nothing
    assign do_wr = wr && cnt != CW'(DEPTH);
    assign do_rd = rd && !empty;
    assign empty = cnt == '0;
    assign full  = cnt >= CW'(DEPTH - FLUX + 1);
    assign dout  = mem[rp];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
            if (do_rd) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= din;
endmodule

module hevc_interp_8tap #(parameter int DEPTH = 4, parameter int FLUX = 2) (
    input logic            clk,
    input logic            rst,
    write_interface.slave  write_port_v_alpha,
    write_interface.slave  write_port_h_alpha,
    write_interface.slave  write_port_ext_size,
    write_interface.slave  write_port_in_port,
    write_interface.master write_port_out_port
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t             state, state_nx;
    logic [2:0]         va_d, ha_d;
    logic [6:0]         es_d;
    logic [7:0]         px_d;
    logic               va_e, ha_e, es_e, px_e;
    logic               cfg_pop, px_pop, adv;
    logic [1:0]         v_sel, h_sel;
    logic [6:0]         e, row, col;
    logic [7:0]         sr [8];
    logic               s1_v, s2_v, ov;
    logic [6:0]         s1_row, s1_col, s2_row;
    logic [5:0]         s2_col;
    logic signed [15:0] h_sum, h_reg;
    logic signed [23:0] v_acc, v_fin;
    logic [7:0]         opix, pix_nx;
    logic signed [15:0] lb [8][64];
    logic               unused_bits;

    assign unused_bits = ^{va_d[0], ha_d[0], write_port_v_alpha.din[3], write_port_h_alpha.din[3],
                           write_port_ext_size.din[7], write_port_in_port.din[8]};

    hevc_interp_fifo #(.W(3), .DEPTH(DEPTH), .FLUX(FLUX)) u_va (.clk(clk), .rst(rst),
        .din(write_port_v_alpha.din[2:0]), .wr(write_port_v_alpha.write), .full(write_port_v_alpha.full),
        .dout(va_d), .empty(va_e), .rd(cfg_pop));
    hevc_interp_fifo #(.W(3), .DEPTH(DEPTH), .FLUX(FLUX)) u_ha (.clk(clk), .rst(rst),
        .din(write_port_h_alpha.din[2:0]), .wr(write_port_h_alpha.write), .full(write_port_h_alpha.full),
        .dout(ha_d), .empty(ha_e), .rd(cfg_pop));
    hevc_interp_fifo #(.W(7), .DEPTH(DEPTH), .FLUX(FLUX)) u_es (.clk(clk), .rst(rst),
        .din(write_port_ext_size.din[6:0]), .wr(write_port_ext_size.write), .full(write_port_ext_size.full),
        .dout(es_d), .empty(es_e), .rd(cfg_pop));
    hevc_interp_fifo #(.W(8), .DEPTH(DEPTH), .FLUX(FLUX)) u_px (.clk(clk), .rst(rst),
        .din(write_port_in_port.din[7:0]), .wr(write_port_in_port.write), .full(write_port_in_port.full),
        .dout(px_d), .empty(px_e), .rd(px_pop));

    // kernel rows packed as {t7..t0}, two's complement bytes
    function automatic logic signed [7:0] tap(input logic [1:0] s, input logic [2:0] k);
        logic [63:0] t;
        t = s == 2'd0 ? 64'h00000000_40000000 :
            s == 2'd1 ? 64'h0001FB11_3AF604FF :
            s == 2'd2 ? 64'hFF04F528_28F504FF : 64'hFF04F63A_11FB0100;
        return $signed(t[{k, 3'b000} +: 8]);
    endfunction

    // the whole pipeline moves only when the consumer can take a pixel
    assign adv = !write_port_out_port.full;
    assign write_port_out_port.write = ov && adv;
    assign write_port_out_port.din = (ov && adv) ? {1'b1, opix} : 9'd0;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        cfg_pop = 1'b0;
        px_pop = 1'b0;
        case (state)
            IDLE: if (!va_e && !ha_e && !es_e) begin
                cfg_pop = 1'b1;
                state_nx = RUN;
            end
            RUN: if (row == e) state_nx = DRAIN;
                 else px_pop = adv && !px_e;
            DRAIN: if (!s1_v && !s2_v && !ov) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            row <= '0;
            col <= '0;
            e <= '0;
            v_sel <= '0;
            h_sel <= '0;
        end else if (cfg_pop) begin
            row <= '0;
            col <= '0;
            e <= es_d;
            v_sel <= va_d[2:1];
            h_sel <= ha_d[2:1];
        end else if (px_pop) begin
            col <= (col == e - 7'd1) ? '0 : col + 7'd1;
            row <= (col == e - 7'd1) ? row + 7'd1 : row;
        end

    always_ff @(posedge clk)
        if (px_pop) begin
            for (int k = 0; k < 7; k++) sr[k] <= sr[k + 1];
            sr[7] <= px_d;
        end

    always_comb begin
        h_sum = '0;
        for (int k = 0; k < 8; k++) h_sum = h_sum + 16'(tap(h_sel, 3'(k))) * 16'($signed({1'b0, sr[k]}));
    end

    // rows r..r+6 come from the line buffer, row r+7 is the H value in flight
    always_comb begin
        v_acc = 24'(tap(v_sel, 3'd7)) * 24'(h_reg);
        for (int k = 0; k < 7; k++)
            v_acc = v_acc + 24'(tap(v_sel, 3'(k))) * 24'(lb[3'(s2_row + 7'(k) + 7'd1)][s2_col]);
        v_fin = ((v_acc >>> 6) + 24'sd32) >>> 6;
`ifdef OUT_CLIP_EN
        pix_nx = v_fin < 24'sd0 ? 8'd0 : v_fin > 24'sd255 ? 8'd255 : v_fin[7:0];
`else
        pix_nx = v_fin[7:0];
`endif
    end

    always_ff @(posedge clk)
        if (adv && s2_v) lb[s2_row[2:0]][s2_col] <= h_reg;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_v <= 1'b0;
            s1_row <= '0;
            s1_col <= '0;
            s2_v <= 1'b0;
            s2_row <= '0;
            s2_col <= '0;
            h_reg <= '0;
            ov <= 1'b0;
            opix <= '0;
        end else if (adv) begin
            s1_v <= px_pop && col >= 7'd7;
            s1_row <= row;
            s1_col <= col;
            s2_v <= s1_v;
            s2_row <= s1_row;
            s2_col <= 6'(s1_col - 7'd7);
            h_reg <= h_sum;
            ov <= s2_v && s2_row >= 7'd7;
            opix <= pix_nx;
        end
endmodule

// File: tb/tb_hevc_interp_8tap.sv
// tb_hevc_interp_8tap: random stimulus against a direct arithmetic model of the interpolation.
`timescale 1ns/1ps
module tb_hevc_interp_8tap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    write_interface #(.W(3), .FLUX(2)) va_if ();
    write_interface #(.W(3), .FLUX(2)) ha_if ();
    write_interface #(.W(7), .FLUX(2)) es_if ();
    write_interface #(.W(8), .FLUX(2)) px_if ();
    write_interface #(.W(8), .FLUX(2)) out_if ();

    hevc_interp_8tap #(.DEPTH(4), .FLUX(2)) dut (
        .clk(clk), .rst(rst),
        .write_port_v_alpha(va_if), .write_port_h_alpha(ha_if), .write_port_ext_size(es_if),
        .write_port_in_port(px_if), .write_port_out_port(out_if));

    int taps [4][8] = '{'{0, 0, 0, 64, 0, 0, 0, 0},
                        '{-1, 4, -10, 58, 17, -5, 1, 0},
                        '{-1, 4, -11, 40, 40, -11, 4, -1},
                        '{0, 1, -5, 17, 58, -10, 4, -1}};
    int pix [5041];
    int hv [71][64];
    int exp_q [$];
    int total = 0, bad = 0;
    int got_n = 0, exp_n = 0, first_out = 0;
    bit force_full = 0, rand_bp = 0, saw_full = 0;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic model(input int e, input int va, input int ha);
        int n, s, o;
        n = e - 7;
        exp_n = n > 0 ? n * n : 0;
        for (int i = 0; i < e; i++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += taps[ha / 2][k] * pix[i * e + c + k];
                hv[i][c] = s;
            end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += taps[va / 2][k] * hv[r + k][c];
                o = ((s >>> 6) + 32) >>> 6;
`ifdef OUT_CLIP_EN
                o = o < 0 ? 0 : o > 255 ? 255 : o;
`else
                o = o & 255;
`endif
                exp_q.push_back(o);
            end
    endtask

    always @(posedge clk) begin
        #1;
        out_if.full = force_full || (rand_bp && $urandom_range(0, 5) == 0);
    end

    always @(negedge clk)
        if (!rst) begin
            if (out_if.full) chk("wr_full", int'(out_if.write), 0);
            if (!out_if.write) chk("idle_din", int'(out_if.din), 0);
            if (out_if.write) begin
                if (got_n == 0) first_out = int'(out_if.din[7:0]);
                got_n++;
                if (exp_q.size() == 0) chk("extra_out", got_n, exp_n);
                else chk("pix", int'(out_if.din), 256 + exp_q.pop_front());
            end
        end

    task automatic send_cfg(input int va, input int ha, input int e);
        int w;
        w = 0;
        while ((va_if.full || ha_if.full || es_if.full) && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("cfg_wait", int'(w >= 1000), 0);
        va_if.din = {1'($urandom_range(0, 1)), 3'(va)};
        ha_if.din = {1'($urandom_range(0, 1)), 3'(ha)};
        es_if.din = {1'($urandom_range(0, 1)), 7'(e)};
        va_if.write = 1; ha_if.write = 1; es_if.write = 1;
        @(posedge clk); #1;
        va_if.write = 0; ha_if.write = 0; es_if.write = 0;
    endtask

    task automatic send_pixels(input int n, input bit gaps);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while ((px_if.full || (gaps && $urandom_range(0, 9) == 0)) && w < 2000) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 2000) begin
                chk("px_stuck", w, 0);
                return;
            end
            px_if.din = {1'($urandom_range(0, 1)), 8'(pix[i])};
            px_if.write = 1;
            @(posedge clk); #1;
            px_if.write = 0;
        end
    endtask

    task automatic stall_mid;
        int w;
        w = 0;
        while (got_n < 100 && w < 5000) begin
            @(posedge clk); #1;
            w++;
        end
        force_full = 1;
        repeat (20) begin
            @(posedge clk); #1;
            if (px_if.full) saw_full = 1;
        end
        force_full = 0;
    endtask

    // mode: 0 ramp, 1 flat 100, 2 dark/bright column step, 3 random
    task automatic run_block(input int va, input int ha, input int e, input int mode, input bit bp);
        int w;
        for (int i = 0; i < e * e; i++)
            pix[i] = mode == 0 ? (i & 255) : mode == 1 ? 100 : mode == 2 ? ((i % e) < 3 ? 0 : 255)
                                                                          : int'($urandom_range(0, 255));
        got_n = 0;
        model(e, va, ha);
        send_cfg(va, ha, e);
        fork
            send_pixels(e * e, !bp);
            if (bp) stall_mid();
        join
        w = 0;
        while (got_n < exp_n && w < 20000) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("count", got_n, exp_n);
    endtask

    initial begin
        va_if.write = 0; ha_if.write = 0; es_if.write = 0; px_if.write = 0;
        va_if.din = 0; ha_if.din = 0; es_if.din = 0; px_if.din = 0;
        out_if.full = 0;
        repeat (10) begin
            @(negedge clk);
            chk("rst_wr", int'(out_if.write), 0);
        end
        chk("rst_full_va", int'(va_if.full), 0);
        chk("rst_full_ha", int'(ha_if.full), 0);
        chk("rst_full_es", int'(es_if.full), 0);
        chk("rst_full_px", int'(px_if.full), 0);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("post_rst_wr", int'(out_if.write), 0);
        chk("post_rst_full", int'(px_if.full), 0);
        @(posedge clk); #1;

        run_block(0, 0, 15, 0, 0);
        chk("copy00", first_out, 48);
        run_block(4, 4, 23, 1, 0);
        chk("flat00", first_out, 100);
        run_block(0, 2, 15, 2, 0);
`ifdef OUT_CLIP_EN
        chk("clip00", first_out, 255);
`else
        chk("clip00", first_out, 27);
`endif
        run_block(2, 2, 23, 3, 0);
        run_block(2, 2, 23, 3, 1);
        chk("in_full_seen", int'(saw_full), 1);
        run_block($urandom_range(0, 7), $urandom_range(0, 7), 5, 3, 0);
        rand_bp = 1;
        repeat (3) run_block($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(8, 24), 3, 0);
        run_block($urandom_range(0, 7), $urandom_range(0, 7), 8, 3, 0);
        rand_bp = 0;
        run_block($urandom_range(0, 7), $urandom_range(0, 7), 71, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
